// File: rtl/pw_utmi_tx_pkg.sv
// pw_utmi_tx_pkg: opmode/PID-type constants, FSM encoding and the
// byte-wide CRC16 step shared by the UTMI+ transmitter.
package pw_utmi_tx_pkg;

  localparam logic [1:0] OPMODE_NONDRIVING = 2'b01;
  localparam logic [1:0] OPMODE_NORMAL     = 2'b00;

  localparam logic [1:0] PID_TYPE_HS   = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA = 2'b11;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SETTLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP
  } state_t;

  // Reflected CRC16, bits taken LSB first as they go on the wire.
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  b
  );
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC16_POLY_REF;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pw_crc16.sv
// pw_crc16: CRC16 accumulator for the transmit path
// (clear on packet start, one byte per enable).
module pw_crc16
  import pw_utmi_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset_i || clr) crc_q <= CRC16_INIT;
    else if (en)        crc_q <= crc16_byte(crc_q, din);
  end

  assign crc = crc_q;

endmodule

// File: rtl/pw_utmi_tx.sv
// pw_utmi_tx: UTMI+ packet transmitter (PID, payload, CRC16).
// Define PW_TX_CRC16_EN to generate CRC16 for DATA PIDs in hardware.
module pw_utmi_tx
  import pw_utmi_tx_pkg::*;
#(
  parameter int pOPMODE_SETTLE = 4,
  parameter int pEOP_HOLD      = 16
) (
  input  logic       fe_clk,
  input  logic       reset_i,
  input  logic       I_tx_start,
  input  logic [3:0] I_tx_pid,
  input  logic       I_tx_nodata,
  input  logic [7:0] I_tx_gap,
  input  logic [7:0] I_tx_data,
  input  logic       I_tx_data_valid,
  input  logic       I_tx_data_last,
  output logic       O_tx_data_ready,
  input  logic       fe_txready,
  input  logic       fe_rxactive,
  output logic       O_fe_txvalid,
  output logic [7:0] O_fe_data,
  output logic [1:0] O_fe_opmode,
  output logic       O_busy,
  output logic       O_done,
  output logic       O_underrun
);

  localparam logic [7:0] SETTLE_LAST = 8'(pOPMODE_SETTLE - 1);
  localparam logic [7:0] EOP_LAST    = 8'(pEOP_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pid_q, pid_d;
  logic       nodata_q, nodata_d;
  logic       last_q, last_d;
  logic       txvalid_q, txvalid_d;
  logic [7:0] data_q, data_d;
  logic [1:0] opmode_q, opmode_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;

  logic in_tx;
  logic pay_exp;
  logic xfer;

  assign in_tx   = (state_q == ST_PID) || (state_q == ST_DATA);
  assign pay_exp = !nodata_q && (pid_q[1:0] != PID_TYPE_HS);

  assign O_tx_data_ready = in_tx & fe_txready & pay_exp & !last_q;
  assign xfer            = O_tx_data_ready & I_tx_data_valid;

`ifdef PW_TX_CRC16_EN
  logic        data_pid;
  logic        crc_clr;
  logic [15:0] crc;

  assign data_pid = pid_q[1:0] == PID_TYPE_DATA;
  assign crc_clr  = (state_q == ST_IDLE) && I_tx_start;

  pw_crc16 u_crc (
    .clk     (fe_clk),
    .reset_i (reset_i),
    .clr     (crc_clr),
    .en      (xfer),
    .din     (I_tx_data),
    .crc     (crc)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pid_d      = pid_q;
    nodata_d   = nodata_q;
    last_d     = last_q;
    txvalid_d  = txvalid_q;
    data_d     = data_q;
    opmode_d   = opmode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (I_tx_start) begin
          pid_d    = I_tx_pid;
          nodata_d = I_tx_nodata;
          last_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (fe_rxactive) begin
          cnt_d = '0;
        end else if (cnt_q >= I_tx_gap) begin
          cnt_d    = '0;
          opmode_d = OPMODE_NORMAL;
          state_d  = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          txvalid_d = 1'b1;
          data_d    = {~pid_q, pid_q};
          state_d   = ST_PID;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PID, ST_DATA: begin
        // txready means the byte on O_fe_data was just taken.
        if (fe_txready) begin
          if (pay_exp && !last_q) begin
            if (I_tx_data_valid) begin
              data_d  = I_tx_data;
              last_d  = I_tx_data_last;
              state_d = ST_DATA;
            end else begin
              txvalid_d  = 1'b0;
              underrun_d = 1'b1;
              cnt_d      = '0;
              state_d    = ST_EOP;
            end
`ifdef PW_TX_CRC16_EN
          end else if (data_pid) begin
            data_d  = ~crc[7:0];
            state_d = ST_CRC_LO;
`endif
          end else begin
            txvalid_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_EOP;
          end
        end
      end
`ifdef PW_TX_CRC16_EN
      ST_CRC_LO: begin
        if (fe_txready) begin
          data_d  = ~crc[15:8];
          state_d = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (fe_txready) begin
          txvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_EOP;
        end
      end
`endif
      ST_EOP: begin
        if (cnt_q == EOP_LAST) begin
          opmode_d = OPMODE_NONDRIVING;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pid_q      <= '0;
      nodata_q   <= 1'b0;
      last_q     <= 1'b0;
      txvalid_q  <= 1'b0;
      data_q     <= '0;
      opmode_q   <= OPMODE_NONDRIVING;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      nodata_q   <= nodata_d;
      last_q     <= last_d;
      txvalid_q  <= txvalid_d;
      data_q     <= data_d;
      opmode_q   <= opmode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign O_fe_txvalid = txvalid_q;
  assign O_fe_data    = data_q;
  assign O_fe_opmode  = opmode_q;
  assign O_busy       = busy_q;
  assign O_done       = done_q;
  assign O_underrun   = underrun_q;

endmodule
